// File: rtl/uart_tx_sched_if.sv
// ----------------------------------------------------------------------------
// uart_tx_sched_if
//
// Purpose:
//   Bundles the two byte-stream requester handshakes and the UART MMIO bus
//   that the uart_tx_sched block sits between.
//
// Signals:
//   req0_valid / req0_data / req0_ready : requester 0 byte handshake
//   req1_valid / req1_data / req1_ready : requester 1 byte handshake
//   data_address  : UART MMIO address
//   data_store    : UART MMIO write data
//   data_read     : 1 = read, 0 = write
//   data_enable   : MMIO access strobe
//   data_fetch    : UART MMIO read data (bit0 = transmit done)
//
// Modports:
//   master : the scheduler view (drives the MMIO bus, accepts requester bytes)
//   slave  : the environment view (requesters plus the UART MMIO block)
// ----------------------------------------------------------------------------
interface uart_tx_sched_if;
    logic        req0_valid;
    logic [7:0]  req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [7:0]  req1_data;
    logic        req1_ready;
    logic [31:0] data_address;
    logic [31:0] data_store;
    logic        data_read;
    logic        data_enable;
    logic [31:0] data_fetch;

    modport master (
        input  req0_valid, req0_data, req1_valid, req1_data, data_fetch,
        output req0_ready, req1_ready, data_address, data_store, data_read,
               data_enable
    );

    modport slave (
        output req0_valid, req0_data, req1_valid, req1_data, data_fetch,
        input  req0_ready, req1_ready, data_address, data_store, data_read,
               data_enable
    );
endinterface

// File: rtl/uart_tx_sched.sv
// ----------------------------------------------------------------------------
// uart_tx_sched
//
// Purpose:
//   Sole master of the UART MMIO port. After reset it writes the baud divisor
//   once, then moves bytes from two per-requester FIFOs into the UART setchar
//   register, round-robin between requesters. After every setchar write it
//   waits one idle cycle and then polls the status register until bit0
//   (transmit done) is seen.
//
// Ports:
//   clk        : clock
//   rst        : asynchronous active-high reset
//   bus        : uart_tx_sched_if.master (requester handshakes + MMIO bus)
//   init_done  : baud divisor has been written
//   busy       : FSM not idle, or either FIFO holds data
//   tx_count   : number of setchar writes, wraps at 16 bits
//
// Parameters:
//   BASE_ADDR  : UART MMIO base (baud +0x0, setchar +0x8, status +0xC)
//   BAUD_DIV   : value written to the baud register after reset
//   DEPTH      : entries per requester FIFO (power of 2, >= 2)
//
// Optional feature (macro UART_TX_SCHED_LOCK_EN):
//   When defined, a granted requester keeps the port until one of its bytes
//   equal to 8'h0A has been written (packet lock). When undefined, the
//   arbitration is plain per-byte round-robin and no lock state exists.
// ----------------------------------------------------------------------------
module uart_tx_sched #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter logic [31:0] BAUD_DIV  = 32'd434,
    parameter int          DEPTH     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    uart_tx_sched_if.master        bus,
    output logic                   init_done,
    output logic                   busy,
    output logic [15:0]            tx_count
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_WRITE,
        S_GAP,
        S_POLL
    } state_t;

    state_t        state_q;
    logic          initDone_q;
    logic          lastGrant_q;
    logic          grant_q;
    logic [7:0]    wdata_q;
    logic [15:0]   txCount_q;

    logic [7:0]    mem_q   [2][DEPTH];
    logic [AW-1:0] rdPtr_q [2];
    logic [AW-1:0] wrPtr_q [2];
    logic [AW:0]   count_q [2];
    logic [AW-1:0] rdPtr_d [2];
    logic [AW-1:0] wrPtr_d [2];
    logic [AW:0]   count_d [2];

    logic [1:0]    reqValid;
    logic [7:0]    reqData  [2];
    logic [7:0]    headByte [2];
    logic [1:0]    fifoEmpty;
    logic [1:0]    fifoFull;
    logic [1:0]    pushEn;
    logic [1:0]    popEn;

    logic          rrValid;
    logic          rrSel;
    logic          grantValid;
    logic          grantSel;

    logic          busEnable;
    logic          busRead;
    logic [31:0]   busAddress;
    logic [31:0]   busStore;

    logic          unused_fetch_bits;

    assign reqValid   = {bus.req1_valid, bus.req0_valid};
    assign reqData[0] = bus.req0_data;
    assign reqData[1] = bus.req1_data;

    // Only bit0 of the status word carries meaning here.
    assign unused_fetch_bits = ^bus.data_fetch[31:1];

    // FIFO bookkeeping for both requesters. Ready comes from the registered
    // count only, so a full FIFO turns away a push even when the scheduler
    // pops it in the same cycle. A push and pop together leave the count
    // alone; pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            fifoEmpty[i] = (count_q[i] == '0);
            fifoFull[i]  = (count_q[i] == FULL_CNT);
            pushEn[i]    = reqValid[i] & ~fifoFull[i];
            popEn[i]     = (state_q == S_WRITE) && (grant_q == 1'(i));
            headByte[i]  = mem_q[i][rdPtr_q[i]];
            count_d[i]   = count_q[i];
            if (pushEn[i] && !popEn[i]) begin
                count_d[i] = count_q[i] + CNT_ONE;
            end else if (!pushEn[i] && popEn[i]) begin
                count_d[i] = count_q[i] - CNT_ONE;
            end
            wrPtr_d[i] = pushEn[i] ? wrPtr_q[i] + PTR_ONE : wrPtr_q[i];
            rdPtr_d[i] = popEn[i]  ? rdPtr_q[i] + PTR_ONE : rdPtr_q[i];
        end
    end

    // FIFO pointers and occupancy; all of it is cleared by reset so any
    // queued bytes are discarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                count_q[i] <= '0;
                rdPtr_q[i] <= '0;
                wrPtr_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                count_q[i] <= count_d[i];
                rdPtr_q[i] <= rdPtr_d[i];
                wrPtr_q[i] <= wrPtr_d[i];
            end
        end
    end

    // FIFO storage has no reset; an entry is only ever read after it has
    // been written, because grants require a non-empty FIFO.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (pushEn[i]) begin
                mem_q[i][wrPtr_q[i]] <= reqData[i];
            end
        end
    end

    // Plain round-robin choice: a lone non-empty FIFO wins outright, and a
    // tie goes to whichever requester was not granted last.
    always_comb begin
        rrValid = ~fifoEmpty[0] | ~fifoEmpty[1];
        rrSel   = (~fifoEmpty[0] & ~fifoEmpty[1]) ? ~lastGrant_q : fifoEmpty[0];
    end

`ifdef UART_TX_SCHED_LOCK_EN
    logic lock_q;

    // While locked, only the locked requester may be granted, and IDLE
    // waits for it even if the other FIFO has data.
    assign grantValid = lock_q ? ~fifoEmpty[grant_q] : rrValid;
    assign grantSel   = lock_q ? grant_q : rrSel;

    // The lock is re-evaluated on each setchar write: it stays held until
    // the byte just written is a line feed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q <= 1'b0;
        end else if (state_q == S_WRITE) begin
            lock_q <= (wdata_q != 8'h0A);
        end
    end
`else
    assign grantValid = rrValid;
    assign grantSel   = rrSel;
`endif

    // Main scheduler FSM. The byte to write is captured at grant time; the
    // FIFO head cannot change before the pop in WRITE, since only pushes
    // touch it meanwhile and the FIFO is already non-empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_INIT;
            initDone_q  <= 1'b0;
            lastGrant_q <= 1'b1;
            grant_q     <= 1'b0;
            wdata_q     <= 8'h00;
            txCount_q   <= 16'h0000;
        end else begin
            case (state_q)
                S_INIT: begin
                    initDone_q <= 1'b1;
                    state_q    <= S_IDLE;
                end
                S_IDLE: begin
                    if (grantValid) begin
                        grant_q     <= grantSel;
                        lastGrant_q <= grantSel;
                        wdata_q     <= headByte[grantSel];
                        state_q     <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    txCount_q <= txCount_q + 16'd1;
                    state_q   <= S_GAP;
                end
                S_GAP: begin
                    state_q <= S_POLL;
                end
                S_POLL: begin
                    if (bus.data_fetch[0]) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_INIT;
                end
            endcase
        end
    end

    // MMIO bus is a pure decode of the registered state. Reset forces it to
    // zero straight away so the UART never sees a strobe during reset.
    always_comb begin
        busEnable  = 1'b0;
        busRead    = 1'b0;
        busAddress = 32'h0;
        busStore   = 32'h0;
        if (!rst) begin
            case (state_q)
                S_INIT: begin
                    busEnable  = 1'b1;
                    busAddress = BASE_ADDR;
                    busStore   = BAUD_DIV;
                end
                S_WRITE: begin
                    busEnable  = 1'b1;
                    busAddress = BASE_ADDR + 32'h8;
                    busStore   = {24'h0, wdata_q};
                end
                S_POLL: begin
                    busEnable  = 1'b1;
                    busRead    = 1'b1;
                    busAddress = BASE_ADDR + 32'hC;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.data_enable  = busEnable;
    assign bus.data_read    = busRead;
    assign bus.data_address = busAddress;
    assign bus.data_store   = busStore;
    assign bus.req0_ready   = ~fifoFull[0];
    assign bus.req1_ready   = ~fifoFull[1];

    assign init_done = initDone_q;
    assign busy      = (state_q != S_IDLE) | ~fifoEmpty[0] | ~fifoEmpty[1];
    assign tx_count  = txCount_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_sched
//
// Self-checking bench for uart_tx_sched. A small UART model answers status
// polls after a programmable number of POLL cycles (or holds transmit-done
// low), a monitor records every setchar write, and a byte-level reference
// model predicts the order in which queued bytes should leave. The packet
// lock behaviour follows macro UART_TX_SCHED_LOCK_EN, same as the design.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx_sched;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [31:0] BAUD = 32'd434;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        initDone;
    logic        busy;
    logic [15:0] txCount;

    int          checks = 0;
    int          failures = 0;

    int          pollSeen = 0;
    int          pollLat = 3;
    bit          holdStatus = 1'b0;
    logic [31:0] junk = 32'h0;
    logic        isPoll;

    logic [7:0]  gotQ [$];
    logic [7:0]  m0Q  [$];
    logic [7:0]  m1Q  [$];
    logic [7:0]  expQ [$];
    int          mLast = 1;
    bit          mLock = 1'b0;
    int          mLockId = 0;

    logic [7:0]  exp6 [5];
    int          n0;
    int          n1;
    logic [7:0]  rb;

    uart_tx_sched_if bus();

    uart_tx_sched #(
        .BASE_ADDR (BASE),
        .BAUD_DIV  (BAUD),
        .DEPTH     (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .init_done (initDone),
        .busy      (busy),
        .tx_count  (txCount)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    // UART model: status bit0 rises once the scheduler has been polling for
    // pollLat cycles, unless holdStatus pins it low. Outside a status read
    // the read data is random junk, including bit0.
    assign isPoll = bus.data_enable && bus.data_read && (bus.data_address == BASE + 32'hC);
    assign bus.data_fetch = isPoll ? {junk[31:1], (!holdStatus && (pollSeen >= pollLat - 1))} : junk;

    always @(posedge clk) begin
        pollSeen <= isPoll ? pollSeen + 1 : 0;
        junk     <= $urandom;
    end

    // Monitor: collect every setchar write as it appears on the bus.
    always @(negedge clk) begin
        if (!rst && bus.data_enable && !bus.data_read && (bus.data_address == BASE + 32'h8)) begin
            gotQ.push_back(bus.data_store[7:0]);
        end
    end

    // Safety net so the run always ends.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Push one byte on requester id, waiting (bounded) for ready.
    task automatic applyStimulus(input int id, input logic [7:0] b);
        int   waitCycles;
        logic rdy;
        waitCycles = 0;
        if (id == 0) begin
            bus.req0_valid = 1'b1;
            bus.req0_data  = b;
        end else begin
            bus.req1_valid = 1'b1;
            bus.req1_data  = b;
        end
        rdy = (id == 0) ? bus.req0_ready : bus.req1_ready;
        while (!rdy && waitCycles < 200) begin
            @(negedge clk);
            waitCycles++;
            rdy = (id == 0) ? bus.req0_ready : bus.req1_ready;
        end
        checkOutput($sformatf("push_ready_req%0d", id), rdy, 1);
        @(posedge clk);
        #1;
        if (id == 0) begin
            bus.req0_valid = 1'b0;
            m0Q.push_back(b);
        end else begin
            bus.req1_valid = 1'b0;
            m1Q.push_back(b);
        end
    endtask

    // Reference model: drain the queued bytes in the order the arbitration
    // rules dictate, stopping if a held lock leaves nothing grantable.
    task automatic modelDrain();
        int         g;
        logic [7:0] b;
        forever begin
            g = -1;
            if (mLock) begin
                if (mLockId == 0 && m0Q.size() > 0) g = 0;
                if (mLockId == 1 && m1Q.size() > 0) g = 1;
            end else if (m0Q.size() > 0 && m1Q.size() > 0) begin
                g = 1 - mLast;
            end else if (m0Q.size() > 0) begin
                g = 0;
            end else if (m1Q.size() > 0) begin
                g = 1;
            end
            if (g < 0) break;
            b = (g == 0) ? m0Q.pop_front() : m1Q.pop_front();
            expQ.push_back(b);
            mLast = g;
`ifdef UART_TX_SCHED_LOCK_EN
            mLock   = (b != 8'h0A);
            mLockId = g;
`endif
        end
    endtask

    // Reset, check reset values, then check the single baud write cycle.
    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        #1;
        checkOutput("rst_enable_immediate", bus.data_enable, 0);
        holdStatus = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_txcount", txCount, 0);
        checkOutput("rst_initdone", initDone, 0);
        checkOutput("rst_ready0", bus.req0_ready, 1);
        checkOutput("rst_ready1", bus.req1_ready, 1);
        gotQ.delete();
        m0Q.delete();
        m1Q.delete();
        expQ.delete();
        mLast = 1;
        mLock = 1'b0;
        mLockId = 0;
        rst = 1'b0;
        #1;
        checkOutput("init_enable", bus.data_enable, 1);
        checkOutput("init_read", bus.data_read, 0);
        checkOutput("init_address", bus.data_address, BASE);
        checkOutput("init_store", bus.data_store, BAUD);
        @(negedge clk);
        checkOutput("init_after_enable", bus.data_enable, 0);
        checkOutput("init_after_address", bus.data_address, 0);
        checkOutput("init_after_store", bus.data_store, 0);
        checkOutput("init_done_set", initDone, 1);
    endtask

    // Send a 0x0A through requester 1 and leave it stuck in POLL so that
    // further bytes can be queued while nothing moves.
    task automatic startBlocked();
        int n;
        holdStatus = 1'b1;
        applyStimulus(1, 8'h0A);
        modelDrain();
        n = 0;
        while (!isPoll && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("blocker_in_poll", isPoll, 1);
    endtask

    // Wait (bounded) for the predicted writes, then compare everything.
    task automatic finishScenario(input string tag);
        int n;
        n = 0;
        while (gotQ.size() < expQ.size() && n < 800) begin
            @(negedge clk);
            n++;
        end
        repeat (30) @(negedge clk);
        checkOutput({tag, "_count"}, gotQ.size(), expQ.size());
        for (int i = 0; i < expQ.size(); i++) begin
            checkOutput($sformatf("%s_byte%0d", tag, i),
                        (i < gotQ.size()) ? 32'(gotQ[i]) : 32'hxxxx_xxxx, 32'(expQ[i]));
        end
        checkOutput({tag, "_txcount"}, txCount, expQ.size());
        checkOutput({tag, "_busy"}, busy, (m0Q.size() + m1Q.size()) != 0);
    endtask

    initial begin
        bus.req0_valid = 1'b0;
        bus.req0_data  = 8'h00;
        bus.req1_valid = 1'b0;
        bus.req1_data  = 8'h00;
        $display("[TB] start");

        // Test 1: baud write after reset, then an idle bus.
        doReset();
        repeat (3) begin
            @(negedge clk);
            checkOutput("t1_bus_idle", bus.data_enable, 0);
        end

        // Test 2: a single byte with a three-cycle status response.
        pollLat = 3;
        applyStimulus(0, 8'h41);
        @(negedge clk);
        checkOutput("t2_idle_enable", bus.data_enable, 0);
        checkOutput("t2_idle_busy", busy, 1);
        @(negedge clk);
        checkOutput("t2_write_enable", bus.data_enable, 1);
        checkOutput("t2_write_read", bus.data_read, 0);
        checkOutput("t2_write_address", bus.data_address, BASE + 32'h8);
        checkOutput("t2_write_store", bus.data_store, 32'h0000_0041);
        @(negedge clk);
        checkOutput("t2_gap_enable", bus.data_enable, 0);
        checkOutput("t2_gap_address", bus.data_address, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("t2_poll%0d_enable", i), bus.data_enable, 1);
            checkOutput($sformatf("t2_poll%0d_read", i), bus.data_read, 1);
            checkOutput($sformatf("t2_poll%0d_address", i), bus.data_address, BASE + 32'hC);
        end
        @(negedge clk);
        checkOutput("t2_done_enable", bus.data_enable, 0);
        checkOutput("t2_done_txcount", txCount, 1);
        checkOutput("t2_done_busy", busy, 0);
        modelDrain();
        finishScenario("t2");

        // Test 3: two bytes per requester queued together.
        doReset();
        pollLat = 2;
        startBlocked();
        applyStimulus(0, 8'h41);
        applyStimulus(0, 8'h42);
        applyStimulus(1, 8'h78);
        applyStimulus(1, 8'h79);
        holdStatus = 1'b0;
        modelDrain();
        finishScenario("t3");

        // Test 4: back-pressure while transmit-done is held low.
        doReset();
        pollLat = 1;
        holdStatus = 1'b1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 8'($urandom));
        end
        checkOutput("t4_full_ready", bus.req1_ready, 0);
        checkOutput("t4_full_txcount", txCount, 1);
        bus.req1_valid = 1'b1;
        bus.req1_data  = 8'hC3;
        repeat (5) @(negedge clk);
        checkOutput("t4_stalled_ready", bus.req1_ready, 0);
        checkOutput("t4_stalled_txcount", txCount, 1);
        holdStatus = 1'b0;
        applyStimulus(1, 8'hC3);
        modelDrain();
        finishScenario("t4");

        // Test 5: reset in the middle of a poll discards everything.
        doReset();
        holdStatus = 1'b1;
        applyStimulus(0, 8'h11);
        applyStimulus(0, 8'h22);
        applyStimulus(0, 8'h33);
        applyStimulus(1, 8'h44);
        begin
            int n;
            n = 0;
            while (!isPoll && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        checkOutput("t5_in_poll", isPoll, 1);
        doReset();
        repeat (20) @(negedge clk);
        checkOutput("t5_no_setchar", gotQ.size(), 0);
        checkOutput("t5_txcount", txCount, 0);
        checkOutput("t5_busy", busy, 0);

        // Test 6: packet with a line feed on req0 against one byte on req1.
        doReset();
        pollLat = 2;
        startBlocked();
        applyStimulus(0, 8'h68);
        applyStimulus(0, 8'h69);
        applyStimulus(0, 8'h0A);
        applyStimulus(1, 8'h5A);
        holdStatus = 1'b0;
        modelDrain();
        finishScenario("t6");
`ifdef UART_TX_SCHED_LOCK_EN
        exp6 = '{8'h0A, 8'h68, 8'h69, 8'h0A, 8'h5A};
`else
        exp6 = '{8'h0A, 8'h68, 8'h5A, 8'h69, 8'h0A};
`endif
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("t6_fixed_byte%0d", i),
                        (i < gotQ.size()) ? 32'(gotQ[i]) : 32'hxxxx_xxxx, 32'(exp6[i]));
        end

        // Randomised scenarios: random fill levels, bytes and poll latency.
        for (int s = 0; s < 4; s++) begin
            doReset();
            pollLat = $urandom_range(1, 4);
            startBlocked();
            n0 = $urandom_range(0, 4);
            n1 = $urandom_range(0, 4);
            for (int i = 0; i < n0; i++) begin
                rb = ($urandom_range(0, 3) == 0) ? 8'h0A : 8'($urandom);
                applyStimulus(0, rb);
            end
            for (int i = 0; i < n1; i++) begin
                rb = ($urandom_range(0, 3) == 0) ? 8'h0A : 8'($urandom);
                applyStimulus(1, rb);
            end
            holdStatus = 1'b0;
            modelDrain();
            finishScenario($sformatf("rand%0d", s));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
